// File: rtl/sprite_sched_pkg.sv
// rtl/sprite_sched_pkg.sv - shared command fields, states and FIFO entry type for the sprite scheduler
package sprite_sched_pkg;

  localparam int CMD_W       = 32;
  localparam int COMP_ID_LSB = 26;
  localparam int CHILD_LSB   = 21;
  localparam int CTRL_LSB    = 17;
  localparam int DTYPE_LSB   = 14;
  localparam int BUF_SEL_BIT = 13;
  localparam int MSG_LSB     = 0;

  localparam logic [3:0] CTRL_NOP    = 4'h0;
  localparam logic [3:0] CTRL_UPDATE = 4'h1;
  localparam logic [3:0] CTRL_SWAP   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_WAIT_VBL,
    ST_SWAP
  } sched_state_t;

  // marker=1 entries are buffer-swap commits; their word is unused
  typedef struct packed {
    logic             marker;
    logic [CMD_W-1:0] word;
  } fifo_entry_t;

  function automatic logic [CMD_W-1:0] stamp_buffer(input logic [CMD_W-1:0] word,
                                                    input logic             buf_sel);
    logic [CMD_W-1:0] w;
    w              = word;
    w[BUF_SEL_BIT] = buf_sel;
    return w;
  endfunction

  function automatic logic [CMD_W-1:0] swap_word(input logic buf_sel);
    logic [CMD_W-1:0] w;
    w                   = '0;
    w[CTRL_LSB +: 4]    = CTRL_SWAP;
    w[BUF_SEL_BIT]      = buf_sel;
    return w;
  endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// rtl/sprite_cmd_fifo.sv - synchronous command FIFO with registered read data and head marker peek
module sprite_cmd_fifo
  import sprite_sched_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fifo_entry_t   push_data,
  input  logic          pop,
  output fifo_entry_t   rd_data,
  output logic          head_marker,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   rd_data_q, rd_data_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign rd_data     = rd_data_q;
  assign head_marker = mem_q[rd_ptr_q].marker;

  // a full FIFO refuses pushes even when a pop happens in the same cycle
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// rtl/sprite_cmd_scheduler.sv - Avalon-MM command queue that broadcasts sprite commands and swaps buffers on vblank
module sprite_cmd_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        active_buffer
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_t  state_q, state_d;
  logic          shown_q, shown_d;
  logic          active_buffer_q, active_buffer_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [31:0]   readdata_q, readdata_d;

  logic          push;
  logic          pop;
  fifo_entry_t   push_data;
  fifo_entry_t   fifo_rd_data;
  logic          fifo_head_marker;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [5:0]    count6;
  logic          vblank;
  logic [31:0]   status;

  assign waitrequest   = chipselect && write && fifo_full;
  assign push          = chipselect && write && !fifo_full &&
                         ((address == 2'd0) || (address == 2'd1));
  assign active_buffer = active_buffer_q;
  assign readdata      = readdata_q;
  assign vblank        = (vcount == VBLANK_LINE) && (hcount == 10'd0);
  assign count6        = 6'(fifo_count);
  assign status        = {frame_count_q, 7'h0, count6, (state_q == ST_WAIT_VBL),
                          active_buffer_q, fifo_full};

  // commands are stamped for the back buffer as seen at the moment they are queued
  always_comb begin
    push_data.marker = (address == 2'd1);
    push_data.word   = (address == 2'd1) ? 32'h0 : stamp_buffer(writedata, ~active_buffer_q);
  end

  sprite_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .rd_data     (fifo_rd_data),
    .head_marker (fifo_head_marker),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count)
  );

  always_comb begin
    state_d         = state_q;
    pop             = 1'b0;
    shown_d         = 1'b0;
    active_buffer_d = active_buffer_q;
    frame_count_d   = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end else begin
          pop     = 1'b1;
          shown_d = 1'b1;
          if (fifo_head_marker) begin
            state_d = ST_WAIT_VBL;
          end else if ((fifo_count == CW'(1)) && !push) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_VBL: begin
        if (vblank) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        active_buffer_d = ~active_buffer_q;
        frame_count_d   = frame_count_q + 16'd1;
        state_d         = (fifo_empty && !push) ? ST_IDLE : ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // popped markers read back as a no-op cycle
  always_comb begin
    cmd_out = 32'h0;
    if (shown_q && !fifo_rd_data.marker) begin
      cmd_out = fifo_rd_data.word;
    end else if (state_q == ST_SWAP) begin
      cmd_out = swap_word(~active_buffer_q);
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (chipselect && read) begin
      readdata_d = (address == 2'd2) ? status : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      shown_q         <= 1'b0;
      active_buffer_q <= 1'b0;
      frame_count_q   <= 16'h0;
      readdata_q      <= 32'h0;
    end else begin
      state_q         <= state_d;
      shown_q         <= shown_d;
      active_buffer_q <= active_buffer_d;
      frame_count_q   <= frame_count_d;
      readdata_q      <= readdata_d;
    end
  end

endmodule
